// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and DataMemory.
// With DMEM_ARB_STATS_EN defined the bundle also carries the access/conflict counters.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    // Requester 0 (CPU load/store path)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic [DATA_W-1:0] rdata0;
    logic              valid0;

    // Requester 1 (debug/loader port)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic [DATA_W-1:0] rdata1;
    logic              valid1;

    // DataMemory side
    logic [ADDR_W-1:0] mem_address;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0]       acc_cnt0;
    logic [15:0]       acc_cnt1;
    logic [15:0]       conflict_cnt;
`endif

    // Arbiter view
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rdata0, valid0,
        output gnt1, rdata1, valid1,
`ifdef DMEM_ARB_STATS_EN
        output acc_cnt0, acc_cnt1, conflict_cnt,
`endif
        output mem_address, mem_we, mem_wdata
    );

    // Requester view (both ports driven from one agent)
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
`ifdef DMEM_ARB_STATS_EN
        input  acc_cnt0, acc_cnt1, conflict_cnt,
`endif
        input  gnt0, rdata0, valid0,
        input  gnt1, rdata1, valid1
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port DataMemory.
// Grants are registered; the memory mux follows the granted port combinationally.
// Optional: DMEM_ARB_STATS_EN adds saturating per-port access and conflict counters.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d, hold_inc;
    logic              rr_q, rr_d;   // 1: port 1 preferred on a tie
    logic              acc0, acc1;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              valid0_q, valid1_q;

    assign acc0     = bus.req0 & (state_q == StGnt0);
    assign acc1     = bus.req1 & (state_q == StGnt1);
    assign hold_inc = hold_q + HW'(1);

    assign bus.gnt0   = (state_q == StGnt0);
    assign bus.gnt1   = (state_q == StGnt1);
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign bus.valid0 = valid0_q;
    assign bus.valid1 = valid1_q;

    // Memory mux: only the granted port reaches DataMemory
    always_comb begin
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.mem_we      = 1'b0;
        if (state_q == StGnt0) begin
            bus.mem_address = bus.addr0;
            bus.mem_wdata   = bus.wdata0;
            bus.mem_we      = bus.we0 & bus.req0;
        end else if (state_q == StGnt1) begin
            bus.mem_address = bus.addr1;
            bus.mem_wdata   = bus.wdata1;
            bus.mem_we      = bus.we1 & bus.req1;
        end
    end

    // Next grant, hold counter and round-robin pointer
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        case (state_q)
            StIdle: begin
                if (bus.req0 && bus.req1) state_d = rr_q ? StGnt1 : StGnt0;
                else if (bus.req0)        state_d = StGnt0;
                else if (bus.req1)        state_d = StGnt1;
            end
            StGnt0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? StGnt1 : StIdle;
                end else if (hold_inc == HW'(MAX_HOLD)) begin
                    if (bus.req1) state_d = StGnt1;
                    else          hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
            StGnt1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? StGnt0 : StIdle;
                end else if (hold_inc == HW'(MAX_HOLD)) begin
                    if (bus.req0) state_d = StGnt0;
                    else          hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: state_d = StIdle;
        endcase
        // Any grant change restarts the hold count and favours the port not just served
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == StGnt0)      rr_d = 1'b1;
            else if (state_d == StGnt1) rr_d = 1'b0;
            else                        rr_d = (state_q == StGnt0);
        end
    end

    // Arbitration state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
        end
    end

    // Capture read data one cycle after an accepted read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            valid0_q <= acc0 & ~bus.we0;
            valid1_q <= acc1 & ~bus.we1;
            if (acc0 && !bus.we0) rdata0_q <= bus.mem_rdata;
            if (acc1 && !bus.we1) rdata1_q <= bus.mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] acc_cnt0_q, acc_cnt1_q, conflict_cnt_q;

    assign bus.acc_cnt0     = acc_cnt0_q;
    assign bus.acc_cnt1     = acc_cnt1_q;
    assign bus.conflict_cnt = conflict_cnt_q;

    // Saturating usage counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_cnt0_q     <= '0;
            acc_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (acc0 && acc_cnt0_q != 16'hFFFF) acc_cnt0_q <= acc_cnt0_q + 16'd1;
            if (acc1 && acc_cnt1_q != 16'hFFFF) acc_cnt1_q <= acc_cnt1_q + 16'd1;
            if (bus.req0 && bus.req1 && conflict_cnt_q != 16'hFFFF) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int MAX_HOLD = 4;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input logic [4:0] i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    // DataMemory stand-in: sync write, combinational read
    bit [31:0] dm [32];
    bit [31:0] written;
    always @(posedge clock) begin
        if (bus.mem_we) begin
            dm[bus.mem_address[6:2]]      <= bus.mem_wdata;
            written[bus.mem_address[6:2]] <= 1'b1;
        end
    end
    assign bus.mem_rdata = written[bus.mem_address[6:2]] ? dm[bus.mem_address[6:2]]
                                                         : init_word(bus.mem_address[6:2]);

    // Reference model state (owner -1 = nobody)
    bit [31:0]   ref_mem [32];
    int          m_owner, m_run, m_fav;
    logic [31:0] m_rdata [2];
    bit          m_valid [2];
    int          m_acc [2];
    int          m_conf;

    bit          in_req [2];
    bit          in_we [2];
    logic [6:0]  in_addr [2];
    logic [31:0] in_wdata [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_fav   = 0;
        m_conf  = 0;
        for (int i = 0; i < 2; i++) begin
            m_rdata[i] = '0;
            m_valid[i] = 1'b0;
            m_acc[i]   = 0;
        end
    endtask

    // One clock edge of the arbitration rules
    task automatic model_step();
        int nxt, o, y;
        logic [4:0] idx;
        if (in_req[0] && in_req[1] && m_conf < 65535) m_conf++;
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        nxt = m_owner;
        if (m_owner < 0) begin
            if (in_req[0] && in_req[1]) nxt = m_fav;
            else if (in_req[0])         nxt = 0;
            else if (in_req[1])         nxt = 1;
        end else begin
            o = m_owner;
            y = 1 - o;
            if (!in_req[o]) begin
                nxt = in_req[y] ? y : -1;
            end else begin
                idx = in_addr[o][6:2];
                if (m_acc[o] < 65535) m_acc[o]++;
                if (in_we[o]) begin
                    ref_mem[idx] = in_wdata[o];
                end else begin
                    m_rdata[o] = ref_mem[idx];
                    m_valid[o] = 1'b1;
                end
                m_run++;
                if (m_run == MAX_HOLD) begin
                    if (in_req[y]) nxt = y;
                    else           m_run = 0;
                end
            end
        end
        if (nxt != m_owner) begin
            m_fav = (nxt >= 0) ? 1 - nxt : 1 - m_owner;
            m_run = 0;
        end
        m_owner = nxt;
    endtask

    task automatic check_outputs();
        bit          acc;
        logic [6:0]  ea;
        logic [31:0] ed;
        acc = (m_owner >= 0) && in_req[(m_owner >= 0) ? m_owner : 0];
        ea  = (m_owner >= 0) ? in_addr[m_owner] : 7'd0;
        ed  = (m_owner >= 0) ? in_wdata[m_owner] : 32'd0;
        check_eq("gnt0", 32'(bus.gnt0), 32'(m_owner == 0));
        check_eq("gnt1", 32'(bus.gnt1), 32'(m_owner == 1));
        check_eq("mem_we", 32'(bus.mem_we), 32'(acc && in_we[(m_owner >= 0) ? m_owner : 0]));
        check_eq("mem_address", 32'(bus.mem_address), 32'(ea));
        check_eq("mem_wdata", bus.mem_wdata, ed);
        check_eq("valid0", 32'(bus.valid0), 32'(m_valid[0]));
        check_eq("valid1", 32'(bus.valid1), 32'(m_valid[1]));
        check_eq("rdata0", bus.rdata0, m_rdata[0]);
        check_eq("rdata1", bus.rdata1, m_rdata[1]);
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [6:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [6:0] a1, input logic [31:0] d1);
        in_req[0] = r0; in_we[0] = w0; in_addr[0] = a0; in_wdata[0] = d0;
        in_req[1] = r1; in_we[1] = w1; in_addr[1] = a1; in_wdata[1] = d1;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic cycle(input bit r0, input bit w0, input logic [6:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [6:0] a1, input logic [31:0] d1);
        @(negedge clock);
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
        #1;
        check_outputs();
        @(posedge clock);
        model_step();
    endtask

    initial begin
        bit r0, r1;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(5'(i));
        reset_n = 1'b0;
        drive(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        #2 reset_n = 1'b1;

        // Port 0 write then read of 0x00
        repeat (2) cycle(1, 1, 7'h00, 32'hA5A5A5A5, 0, 0, 7'd0, 32'd0);
        cycle(1, 0, 7'h00, 32'd0, 0, 0, 7'd0, 32'd0);
        cycle(0, 0, 7'h00, 32'd0, 0, 0, 7'd0, 32'd0);
        check_eq("rdata0_a5", bus.rdata0, 32'hA5A5A5A5);
        cycle(0, 0, 7'h00, 32'd0, 0, 0, 7'd0, 32'd0);

        // Port 1 alone: write then read 0x20
        repeat (2) cycle(0, 0, 7'd0, 32'd0, 1, 1, 7'h20, 32'h12345678);
        cycle(0, 0, 7'd0, 32'd0, 1, 0, 7'h20, 32'd0);
        cycle(0, 0, 7'd0, 32'd0, 0, 0, 7'h20, 32'd0);
        check_eq("rdata1_1234", bus.rdata1, 32'h12345678);
        repeat (2) cycle(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);

        // Both requesting: alternating bursts of MAX_HOLD
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 7'(4 * (i % 8)), 32'd0, 1, 1, 7'(64 + 4 * (i % 8)), 32'(i) * 32'h01010101);
        end
        repeat (2) cycle(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);

        // Port 1 streaming reads of 0x04 past the hold limit
        repeat (12) cycle(0, 0, 7'd0, 32'd0, 1, 0, 7'h04, 32'd0);
        repeat (2) cycle(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);

        // Reset in the middle of a port-0 write burst
        repeat (2) cycle(1, 1, 7'h08, 32'hDEADBEEF, 0, 0, 7'd0, 32'd0);
        @(negedge clock);
        drive(1, 1, 7'h08, 32'hBADBAD00, 0, 0, 7'd0, 32'd0);
        #1;
        check_outputs();
        reset_n = 1'b0;
        #1;
        check_eq("rst_gnt0", 32'(bus.gnt0), 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(bus.mem_address), 32'd0);
        @(posedge clock);
        model_reset();
        #2 reset_n = 1'b1;
        repeat (2) cycle(1, 0, 7'h08, 32'd0, 0, 0, 7'd0, 32'd0);
        cycle(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
        check_eq("rdata0_prior", bus.rdata0, 32'hDEADBEEF);

        // Random traffic with sticky requests to form bursts
        r0 = 0;
        r1 = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 30) r0 = ~r0;
            if ($urandom_range(0, 99) < 30) r1 = ~r1;
            cycle(r0, 1'($urandom), 7'($urandom), $urandom,
                  r1, 1'($urandom), 7'($urandom), $urandom);
        end
        cycle(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);

`ifdef DMEM_ARB_STATS_EN
        check_eq("acc_cnt0", 32'(bus.acc_cnt0), 32'(m_acc[0]));
        check_eq("acc_cnt1", 32'(bus.acc_cnt1), 32'(m_acc[1]));
        check_eq("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conf));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port DataMemory (sync write, combinational read, 7-bit byte address, word index address[6:2]) between requester 0 (CPU load/store path) and requester 1 (debug/loader port).
- Round-robin req/gnt handshake with a bounded hold count.
- Drives DataMemory's address/WriteEnable/WriteData and returns registered read data with a valid pulse.

Parameters:
- ADDR_W, 7, byte address width presented to DataMemory.
- DATA_W, 32, data word width.
- MAX_HOLD, 4, max consecutive accepted accesses per grant while the other port is requesting (≥1).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held high for every access wanted.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 byte address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  port 0 owns memory this cycle.
- rdata0  output  DATA_W  port 0 registered read data.
- valid0  output  1  one-cycle pulse: rdata0 holds result of read accepted previous cycle.
- req1, we1, addr1, wdata1, gnt1, rdata1, valid1: same definitions for port 1.
- mem_address  output  ADDR_W  to DataMemory.address.
- mem_we  output  1  to DataMemory.WriteEnable.
- mem_wdata  output  DATA_W  to DataMemory.WriteData.
- mem_rdata  input  DATA_W  from DataMemory.MemData.

Behaviour:
- Reset (async, reset_n low): state IDLE, rr pointer = port 0 preferred, hold counter 0, gnt0/gnt1/valid0/valid1 = 0, rdata0/rdata1 = 0, mem_we = 0, mem_address = 0, mem_wdata = 0. Reset mid-transfer aborts; mem_we falls immediately, no write commits.
- States: IDLE, GNT0, GNT1. gntN = (state == GNTN), registered. gnt0 and gnt1 never high together.
- Access accepted in a cycle iff reqN && gntN. Accepted write: mem_we = 1 that cycle, commits at the next rising edge. Accepted read: mem_rdata captured into rdataN at the next edge, validN = 1 for exactly one cycle.
- Memory mux is combinational from granted port: mem_address = addrN, mem_wdata = wdataN, mem_we = weN & reqN & gntN. Non-granted/IDLE: address/wdata = 0, mem_we = 0.
- Latency: req asserted in cycle N from IDLE → gnt in N+1 → access in N+1 → write visible / valid in N+2.
- IDLE: if only one req, go to that GNT. If both, go to the port the rr pointer prefers (after reset: port 0).
- GNTx: hold counter increments per accepted access, cleared on entry.
  - reqx low → GNTy if reqy, else IDLE. No idle bubble between grants.
  - Counter reaches MAX_HOLD with reqy high → forced switch to GNTy.
  - Counter reaches MAX_HOLD with reqy low → stay in GNTx, counter clears.
- rr pointer updated on every grant transition to favour the port not just served.
- Cycle where gnt is high but req has dropped: no access, mem_we = 0.
- rdataN holds its last value between reads. validN never asserts for writes.

Optional Feature:
- DMEM_ARB_STATS_EN defined: adds outputs acc_cnt0 and acc_cnt1 (16 bits each).
  - Count accepted accesses per port; saturate at 0xFFFF; cleared by reset.
  - Also adds output conflict_cnt (16 bits, saturating): counts cycles where both req are high.
- Not defined: these ports and their logic are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset then single write: req0 = 1, we0 = 1, addr0 = 7'h00, wdata0 = 32'hA5A5A5A5 → gnt0 next cycle, mem_we = 1 for one cycle. Then read of 7'h00 → valid0 pulse with rdata0 = 32'hA5A5A5A5.
- Port 1 alone: write 32'h12345678 to 7'h20, then read 7'h20 → rdata1 = 32'h12345678, valid1 pulse, gnt0 stays 0.
- Simultaneous req0 = req1 = 1 out of reset, MAX_HOLD = 4 → gnt0 for 4 accesses, then gnt1 the next cycle with no IDLE gap, then back to gnt0 after 4 more. gnt0 & gnt1 never both 1.
- req1 only stays high, continuous reads of 7'h04 → gnt1 held indefinitely, counter wraps, valid1 every cycle from the second grant cycle.
- Mid-burst reset: assert reset_n = 0 during a GNT0 write → mem_we and gnt0 drop within the same cycle. After release, a read of that address returns the prior contents.
- With DMEM_ARB_STATS_EN: 3 port-0 accesses and 2 port-1 accesses with 1 overlapping-request cycle → acc_cnt0 = 3, acc_cnt1 = 2, conflict_cnt = 1.
